// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_scoreboard: ID-stage operand bypass selection, long-latency         |
// | scoreboard, data-stall generation, stall counters and hang watchdog.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_scoreboard #(
  parameter int STAGES = 4,
  parameter int AW     = 5,
  parameter int SELW   = 3,
  parameter int WDOG   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        id_rs,
  input  logic [AW-1:0]        id_rt,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_rs_use,
  input  logic                 id_rt_use,
  input  logic                 id_rd_use,
  input  logic [STAGES-1:0]    st_wr,
  input  logic [STAGES*AW-1:0] st_rd,
  input  logic [STAGES-1:0]    st_rdy,
  input  logic                 iss_valid,
  input  logic                 iss_long,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 cmp_valid,
  input  logic [AW-1:0]        cmp_rd,
  input  logic                 flush,
  output logic [SELW-1:0]      fwd_rs_sel,
  output logic [SELW-1:0]      fwd_rt_sel,
  output logic                 data_stall,
  output logic [(1<<AW)-1:0]   pending,
  output logic [15:0]          stall_run,
  output logic [31:0]          stall_total,
  output logic                 hang
);

  localparam int NREG = 1 << AW;

  logic [AW-1:0]   st_rd_arr [STAGES];
  logic [NREG-1:0] pending_q, pending_d;
  logic [15:0]     stall_run_q, stall_run_d;
  logic [31:0]     stall_total_q, stall_total_d;
  logic            hang_q, hang_d;
  logic [SELW:0]   rs_lookup, rt_lookup;
  logic            rs_sb_hit, rt_sb_hit, waw_hit;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign st_rd_arr[i] = st_rd[i*AW +: AW];
  end

  // Returns {winner_not_ready, sel}; scanning oldest to youngest lets the
  // youngest matching producer overwrite older ones.
  function automatic logic [SELW:0] fwd_lookup(input logic [AW-1:0] src,
                                                input logic          use_i);
    logic [SELW-1:0] sel;
    logic            not_rdy;
    sel     = '0;
    not_rdy = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (use_i && (src != '0) && st_wr[i] && (st_rd_arr[i] == src)) begin
        sel     = SELW'(i + 1);
        not_rdy = !st_rdy[i];
      end
    end
    return {not_rdy, sel};
  endfunction

  always_comb begin
    rs_lookup  = fwd_lookup(id_rs, id_rs_use);
    rt_lookup  = fwd_lookup(id_rt, id_rt_use);
    rs_sb_hit  = id_rs_use && (id_rs != '0) && pending_q[id_rs];
    rt_sb_hit  = id_rt_use && (id_rt != '0) && pending_q[id_rt];
    waw_hit    = id_rd_use && (id_rd != '0) && pending_q[id_rd];
    fwd_rs_sel = rs_lookup[SELW-1:0];
    fwd_rt_sel = rt_lookup[SELW-1:0];
    data_stall = rs_lookup[SELW] || rt_lookup[SELW] || rs_sb_hit || rt_sb_hit || waw_hit;
  end

  // Clear is applied before set so a same-register set/clear leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (cmp_valid) begin
        pending_d[cmp_rd] = 1'b0;
      end
      if (iss_valid && iss_long && (iss_rd != '0)) begin
        pending_d[iss_rd] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    stall_run_d   = '0;
    stall_total_d = stall_total_q;
    hang_d        = hang_q;
    if (data_stall) begin
      stall_run_d   = (stall_run_q == 16'hFFFF) ? stall_run_q : stall_run_q + 16'd1;
      stall_total_d = stall_total_q + 32'd1;
      if (32'(stall_run_q) >= 32'(WDOG - 1)) begin
        hang_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      stall_run_q   <= '0;
      stall_total_q <= '0;
      hang_q        <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      stall_run_q   <= stall_run_d;
      stall_total_q <= stall_total_d;
      hang_q        <= hang_d;
    end
  end

  assign pending     = pending_q;
  assign stall_run   = stall_run_q;
  assign stall_total = stall_total_q;
  assign hang        = hang_q;

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 3-stage bypass/stall logic.
- Generalises forwarding to STAGES producer stages with per-stage data-ready flags.
- Adds a per-register scoreboard for long-latency writers (cache-miss loads, mul/div, CP0 reads), a WAW check, and register-0 suppression.
- Adds stall-run/performance counters and a hang watchdog.
- Sits beside the ID stage; drives the ID operand mux selects and the data-stall request into the pipeline-write control.

Parameters:
- STAGES, 4: number of forwarding source stages; index 0 is youngest (EX), STAGES-1 is oldest (WB).
- AW, 5: register-index width; 2^AW architectural registers.
- SELW, 3: select width; must satisfy 2^SELW > STAGES.
- WDOG, 1024: consecutive-stall cycles before hang is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt, id_rd  in  AW each  ID source and destination indices
- id_rs_use, id_rt_use, id_rd_use  in  1 each  operand actually read / destination written
- st_wr  in  STAGES  stage holds a register write
- st_rd  in  STAGES*AW  stage destination indices, stage i at [i*AW +: AW]
- st_rdy  in  STAGES  stage result value is available for bypass
- iss_valid  in  1  instruction leaves ID this cycle
- iss_long  in  1  that instruction is a long-latency writer
- iss_rd  in  AW  its destination
- cmp_valid  in  1  long-latency result written back
- cmp_rd  in  AW  its destination
- flush  in  1  exception/ERET flush of all in-flight long ops
- fwd_rs_sel, fwd_rt_sel  out  SELW each  0 = register file; k = stage k-1
- data_stall  out  1  hold PC/IF/ID, bubble into EX
- pending  out  2^AW  scoreboard vector
- stall_run  out  16  current consecutive-stall count, saturating
- stall_total  out  32  total stall cycles, wrapping
- hang  out  1  sticky watchdog flag

Behaviour:
- Reset: pending=0, stall_run=0, stall_total=0, hang=0. With idle inputs: fwd sels=0, data_stall=0.
- Forward select is combinational, per source operand:
  - Candidate stages: st_wr[i] && st_rd[i]==src && src!=0 && use.
  - The lowest-index candidate wins (youngest producer).
  - sel = i+1; no candidate gives sel = 0.
- Register 0 never forwards, never stalls, and is never set in pending.
- data_stall (combinational) is the OR of:
  - (a) the winning stage for a used source has st_rdy=0;
  - (b) pending[src]=1 for a used source;
  - (c) WAW: id_rd_use && id_rd!=0 && pending[id_rd].
- Scoreboard update, at the clock edge, in priority order:
  1. rst
  2. flush: clear all bits
  3. set pending[iss_rd] when iss_valid && iss_long && iss_rd!=0
  4. clear pending[cmp_rd] when cmp_valid
- Simultaneous set and clear of the same register: set wins.
- Clears of other registers in that same cycle still apply.
- Completion of a non-pending register is ignored.
- Scoreboard latency: the ID consumer sees pending=1 the cycle after issue; a clear is visible the cycle after completion. The completing value must come from a forwarding stage in that cycle.
- iss_valid while data_stall=1 is illegal; a stalled instruction does not issue.
- stall_run:
  - increments each data_stall cycle, saturating at 16'hFFFF;
  - resets to 0 on the first non-stall cycle.
- stall_total: +1 per data_stall cycle; wraps modulo 2^32.
- hang: set when stall_run reaches WDOG-1 while data_stall is still 1. Held until rst; flush does not clear it.
- Reset asserted mid-stall: all state clears the next edge; stall resumes only if the inputs still demand it.

Test Plan:
1. Forward priority:
   - Stimulus: st_wr=4'b0101, st_rd stages 0 and 2 =5'd8, st_rdy all 1, id_rs=8, id_rs_use=1.
   - Response: fwd_rs_sel=1, data_stall=0.
   - Then clear st_wr[0]: fwd_rs_sel=3.
2. Load-use:
   - Stimulus: stage0 writes r9 with st_rdy[0]=0, id_rt=9 used.
   - Response: data_stall=1, fwd_rt_sel=1.
   - Then st_rdy[0]=1: data_stall=0 the same cycle.
3. Register zero:
   - Stimulus: all stages write r0, id_rs=id_rt=0; also issue long with iss_rd=0.
   - Response: sels=0, data_stall=0, pending=0.
4. Scoreboard:
   - Stimulus: issue long r12.
   - Response: the next cycle pending[12]=1; ID reading r12 sees data_stall=1 and stall_run counts 1,2,3…
   - Then cmp_valid r12: pending[12]=0 next cycle, stall_run=0.
   - Separately: set and clear of r12 in the same cycle leaves pending[12]=1.
5. WAW and flush:
   - Stimulus: pending[5]=1, id_rd=5 with id_rd_use and no source match.
   - Response: data_stall=1.
   - Then flush: pending=0, data_stall=0 next cycle.
6. Watchdog:
   - Stimulus: WDOG=16, hold a pending source for 20 cycles.
   - Response: hang rises on the 16th stall cycle and stays 1 after the stall ends; stall_total=20.
   - rst clears hang.
